// File: rtl/conv_seq_pkg.sv
// Shared types for the conv layer sequencer.
// Descriptor word: {stride, padding, wbase, wlen}.
package conv_seq_pkg;

  localparam int DESC_W   = 32;
  localparam int STRIDE_W = 4;
  localparam int PAD_W    = 4;
  localparam int WBASE_W  = 16;
  localparam int WLEN_W   = 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LOAD_W,
    S_START,
    S_RUN,
    S_NEXT,
    S_DONE,
    S_ERROR
  } state_e;

  typedef struct packed {
    logic [STRIDE_W-1:0] stride;
    logic [PAD_W-1:0]    padding;
    logic [WBASE_W-1:0]  wbase;
    logic [WLEN_W-1:0]   wlen;
  } desc_t;

endpackage

// File: rtl/conv_seq_if.sv
// Control, weight-load and engine bundle of the sequencer.
// master = sequencer side, slave = PS / engine side.
interface conv_seq_if #(
  parameter int NUM_LAYERS = 8
);
  localparam int LAW = $clog2(NUM_LAYERS);

  logic           cfg_we;
  logic [LAW-1:0] cfg_addr;
  logic [31:0]    cfg_wdata;
  logic [LAW:0]   run_layers;
  logic           start;
  logic           abort;
  logic           busy;
  logic           done;
  logic           aborted;
  logic           error;
  logic [LAW-1:0] err_layer;
  logic [LAW-1:0] layer_idx;
  logic           buf_sel;
  logic           wl_req;
  logic [15:0]    wl_base;
  logic [7:0]     wl_len;
  logic           wl_ack;
  logic           eng_start;
  logic           eng_done;
  logic [7:0]     eng_stride;
  logic [7:0]     eng_padding;

  modport master (
    input  cfg_we, cfg_addr, cfg_wdata,
    input  run_layers, start, abort,
    input  wl_ack, eng_done,
    output busy, done, aborted, error,
    output err_layer, layer_idx, buf_sel,
    output wl_req, wl_base, wl_len,
    output eng_start, eng_stride, eng_padding
  );

  modport slave (
    output cfg_we, cfg_addr, cfg_wdata,
    output run_layers, start, abort,
    output wl_ack, eng_done,
    input  busy, done, aborted, error,
    input  err_layer, layer_idx, buf_sel,
    input  wl_req, wl_base, wl_len,
    input  eng_start, eng_stride, eng_padding
  );

endinterface

// File: rtl/conv_desc_ram.sv
// Layer descriptor table: one write port, one registered read port.
// Contents are not reset.
module conv_desc_ram
  import conv_seq_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [AW-1:0]     waddr_i,
  input  logic [DESC_W-1:0] wdata_i,
  input  logic [AW-1:0]     raddr_i,
  output logic [DESC_W-1:0] rdata_o
);

  logic [DESC_W-1:0] mem_q [DEPTH];
  logic [DESC_W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/conv_layer_sequencer.sv
// Steps a layer list through one shared conv engine:
// weight load, engine start, wait done, ping-pong buffers.
module conv_layer_sequencer
  import conv_seq_pkg::*;
#(
  parameter int NUM_LAYERS = 8,
  parameter int TIMEOUT_W  = 20
) (
  input logic        clk,
  input logic        rst_n,
  conv_seq_if.master bus
);

  localparam int LAW = $clog2(NUM_LAYERS);
  localparam logic [LAW:0] MAX_RUN = NUM_LAYERS[LAW:0];
  // Last count before the watchdog would hit all-ones
  localparam logic [TIMEOUT_W-1:0] WD_LAST =
    {{(TIMEOUT_W-1){1'b1}}, 1'b0};

  state_e              state_q, state_d;
  logic [LAW-1:0]      layer_q, layer_d;
  logic [LAW:0]        run_q, run_d;
  logic                buf_q, buf_d;
  logic                abt_q, abt_d;
  logic                err_q, err_d;
  logic [LAW-1:0]      errl_q, errl_d;
  logic [TIMEOUT_W-1:0] wd_q, wd_d;
  desc_t               desc_q, desc_d;

  logic [DESC_W-1:0]   ram_rdata;
  desc_t               fetched;
  logic [LAW:0]        run_clamp;
  logic                ram_we;
  logic                last;

  assign ram_we    = bus.cfg_we && (state_q == S_IDLE);
  assign fetched   = desc_t'(ram_rdata);
  assign run_clamp = (bus.run_layers > MAX_RUN) ?
                     MAX_RUN : bus.run_layers;
  assign last      = ({1'b0, layer_q} == run_q - 1'b1);

  conv_desc_ram #(
    .DEPTH (NUM_LAYERS),
    .AW    (LAW)
  ) u_ram (
    .clk     (clk),
    .we_i    (ram_we),
    .waddr_i (bus.cfg_addr),
    .wdata_i (bus.cfg_wdata),
    .raddr_i (layer_d),
    .rdata_o (ram_rdata)
  );

  always_comb begin
    state_d = state_q;
    layer_d = layer_q;
    run_d   = run_q;
    buf_d   = buf_q;
    abt_d   = abt_q;
    err_d   = err_q;
    errl_d  = errl_q;
    wd_d    = wd_q;
    desc_d  = desc_q;
    unique case (state_q)
      S_IDLE: begin
        if (bus.start && !bus.abort) begin
          run_d   = run_clamp;
          layer_d = '0;
          buf_d   = 1'b0;
          abt_d   = 1'b0;
          err_d   = 1'b0;
          state_d = (run_clamp == '0) ? S_DONE : S_FETCH;
        end
      end
      S_FETCH: begin
        desc_d  = fetched;
        wd_d    = '0;
        state_d = (fetched.wlen == '0) ? S_START : S_LOAD_W;
      end
      S_LOAD_W: begin
        if (bus.wl_ack)          state_d = S_START;
        else if (wd_q == WD_LAST) state_d = S_ERROR;
        else                      wd_d = wd_q + 1'b1;
      end
      S_START: begin
        wd_d    = '0;
        state_d = S_RUN;
      end
      S_RUN: begin
        // Zero count marks the cycle right after START
        if (bus.eng_done && wd_q != '0) state_d = S_NEXT;
        else if (wd_q == WD_LAST)       state_d = S_ERROR;
        else                            wd_d = wd_q + 1'b1;
      end
      S_NEXT: begin
        if (last) begin
          state_d = S_DONE;
        end else begin
          layer_d = layer_q + 1'b1;
          buf_d   = ~buf_q;
          state_d = S_FETCH;
        end
      end
      S_DONE:  state_d = S_IDLE;
      S_ERROR: begin
        err_d   = 1'b1;
        errl_d  = layer_q;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (state_q != S_IDLE && bus.abort) begin
      state_d = S_IDLE;
      abt_d   = 1'b1;
      err_d   = err_q;
      errl_d  = errl_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      layer_q <= '0;
      run_q   <= '0;
      buf_q   <= 1'b0;
      abt_q   <= 1'b0;
      err_q   <= 1'b0;
      errl_q  <= '0;
      wd_q    <= '0;
      desc_q  <= '0;
    end else begin
      state_q <= state_d;
      layer_q <= layer_d;
      run_q   <= run_d;
      buf_q   <= buf_d;
      abt_q   <= abt_d;
      err_q   <= err_d;
      errl_q  <= errl_d;
      wd_q    <= wd_d;
      desc_q  <= desc_d;
    end
  end

  assign bus.busy        = (state_q != S_IDLE);
  assign bus.done        = (state_q == S_DONE);
  assign bus.wl_req      = (state_q == S_LOAD_W);
  assign bus.eng_start   = (state_q == S_START);
  assign bus.aborted     = abt_q;
  assign bus.error       = err_q;
  assign bus.err_layer   = errl_q;
  assign bus.layer_idx   = layer_q;
  assign bus.buf_sel     = buf_q;
  assign bus.wl_base     = desc_q.wbase;
  assign bus.wl_len      = desc_q.wlen;
  assign bus.eng_stride  = {4'b0, desc_q.stride};
  assign bus.eng_padding = {4'b0, desc_q.padding};

endmodule

// File: tb/tb_conv_layer_sequencer.sv
// Directed bench for conv_layer_sequencer with
// weight-load and engine responder models.
module tb_conv_layer_sequencer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  conv_seq_if #(.NUM_LAYERS(8)) bus();

  conv_layer_sequencer #(
    .NUM_LAYERS (8),
    .TIMEOUT_W  (6)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_chk = 0;
  int n_fail = 0;
  int n_wl, n_start, n_done;
  logic [7:0] buf_bits;
  int wl_dly = 5;
  int eng_dly = 40;
  logic hold_en = 1'b0;
  logic [2:0] hold_layer = 3'd0;
  logic eng_force = 1'b0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // weight-load responder: ack wl_dly cycles after req
  initial begin
    int cnt;
    cnt = 0;
    bus.wl_ack = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      bus.wl_ack = 1'b0;
      if (bus.wl_req) begin
        cnt++;
        if (cnt == wl_dly) begin
          bus.wl_ack = 1'b1;
          cnt = 0;
        end
      end else begin
        cnt = 0;
      end
    end
  end

  // engine responder: done eng_dly cycles after start
  initial begin
    int cnt;
    logic act;
    cnt = 0;
    act = 1'b0;
    bus.eng_done = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (!eng_force) bus.eng_done = 1'b0;
      if (bus.eng_start) begin
        cnt = 0;
        act = 1'b1;
        n_start++;
        buf_bits = {buf_bits[6:0], bus.buf_sel};
      end else if (act) begin
        cnt++;
        if (cnt == eng_dly) begin
          act = 1'b0;
          if (!(hold_en && bus.layer_idx == hold_layer))
            bus.eng_done = 1'b1;
        end
      end
      if (!bus.busy) act = 1'b0;
    end
  end

  initial begin
    logic prev;
    prev = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (bus.wl_req && !prev) n_wl++;
      prev = bus.wl_req;
      if (bus.done) n_done++;
    end
  end

  task automatic clr();
    n_wl = 0;
    n_start = 0;
    n_done = 0;
    buf_bits = '0;
  endtask

  task automatic wr(input int a, input logic [3:0] s,
                    input logic [3:0] p,
                    input logic [15:0] b,
                    input logic [7:0] l);
    bus.cfg_we = 1'b1;
    bus.cfg_addr = 3'(a);
    bus.cfg_wdata = {s, p, b, l};
    tick();
    bus.cfg_we = 1'b0;
  endtask

  task automatic go(input int n);
    bus.run_layers = 4'(n);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic wait_end(input int budget,
                          input string tag);
    for (int i = 0; i < budget; i++) begin
      if (!bus.busy) break;
      if (bus.done) begin
        tick();
        break;
      end
      tick();
    end
    chk(tag, 32'(bus.busy), 32'd0);
  endtask

  task automatic wait_start(input int layer,
                            input int budget,
                            input string tag);
    for (int i = 0; i < budget; i++) begin
      if (bus.eng_start &&
          bus.layer_idx == 3'(layer)) break;
      tick();
    end
    chk(tag, 32'(bus.eng_start), 32'd1);
  endtask

  initial begin
    int d;
    bus.cfg_we = 1'b0;
    bus.cfg_addr = '0;
    bus.cfg_wdata = '0;
    bus.run_layers = '0;
    bus.start = 1'b0;
    bus.abort = 1'b0;
    clr();

    repeat (2) @(posedge clk);
    #2;
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_outs",
        {bus.done, bus.wl_req, bus.eng_start,
         bus.error, bus.aborted, bus.buf_sel,
         bus.layer_idx, bus.eng_stride,
         bus.eng_padding}, 32'd0);
    rst_n = 1'b1;
    tick();

    // T1: three layers with weight loads
    wr(0, 4'd1, 4'd0, 16'h1000, 8'd16);
    wr(1, 4'd1, 4'd0, 16'h1100, 8'd16);
    wr(2, 4'd1, 4'd0, 16'h1200, 8'd16);
    clr();
    go(3);
    chk("t1_fetch_busy", 32'(bus.busy), 32'd1);
    chk("t1_fetch_req", 32'(bus.wl_req), 32'd0);
    tick();
    chk("t1_req", 32'(bus.wl_req), 32'd1);
    chk("t1_wbase", 32'(bus.wl_base), 32'h1000);
    chk("t1_wlen", 32'(bus.wl_len), 32'd16);
    wait_end(600, "t1_end");
    chk("t1_nwl", n_wl, 3);
    chk("t1_nstart", n_start, 3);
    chk("t1_bufs", 32'(buf_bits[2:0]), 32'b010);
    chk("t1_ndone", n_done, 1);
    chk("t1_layer", 32'(bus.layer_idx), 32'd2);

    // T2: stride/padding, zero-length weights
    eng_dly = 10;
    wr(0, 4'd2, 4'd1, 16'h2000, 8'd0);
    wr(1, 4'd3, 4'd2, 16'h3000, 8'd4);
    clr();
    go(2);
    tick();
    chk("t2_start", 32'(bus.eng_start), 32'd1);
    chk("t2_noreq", 32'(bus.wl_req), 32'd0);
    chk("t2_stride", 32'(bus.eng_stride), 32'h02);
    chk("t2_pad", 32'(bus.eng_padding), 32'h01);
    repeat (5) tick();
    chk("t2_run_sp",
        {bus.eng_stride, bus.eng_padding}, 32'h0201);
    wait_end(300, "t2_end");
    chk("t2_nwl", n_wl, 1);
    chk("t2_nstart", n_start, 2);
    chk("t2_stride1", 32'(bus.eng_stride), 32'h03);

    // T3: watchdog on layer 1
    eng_dly = 3;
    hold_en = 1'b1;
    hold_layer = 3'd1;
    wr(0, 4'd1, 4'd1, 16'h0, 8'd0);
    wr(1, 4'd1, 4'd1, 16'h0, 8'd0);
    clr();
    go(2);
    wait_start(1, 100, "t3_start1");
    d = 0;
    for (int i = 0; i < 200; i++) begin
      tick();
      d++;
      if (!bus.busy) break;
    end
    chk("t3_cycles", d, 65);
    chk("t3_error", 32'(bus.error), 32'd1);
    chk("t3_errl", 32'(bus.err_layer), 32'd1);
    chk("t3_ndone", n_done, 0);
    hold_en = 1'b0;
    go(1);
    chk("t3_clr", 32'(bus.error), 32'd0);
    wait_end(200, "t3_end");
    chk("t3_ndone2", n_done, 1);

    // T4: abort in RUN of layer 2
    eng_dly = 10;
    for (int i = 0; i < 4; i++)
      wr(i, 4'd1, 4'd0, 16'h0, 8'd0);
    clr();
    go(4);
    wait_start(2, 200, "t4_start2");
    tick();
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    chk("t4_busy", 32'(bus.busy), 32'd0);
    chk("t4_aborted", 32'(bus.aborted), 32'd1);
    chk("t4_estart", 32'(bus.eng_start), 32'd0);
    repeat (3) tick();
    chk("t4_ndone", n_done, 0);
    bus.run_layers = 4'd2;
    bus.start = 1'b1;
    bus.abort = 1'b1;
    tick();
    bus.start = 1'b0;
    bus.abort = 1'b0;
    chk("t4_ab_st", 32'(bus.busy), 32'd0);
    chk("t4_ab_sticky", 32'(bus.aborted), 32'd1);

    // T5: zero layers, clamped layer count
    eng_dly = 3;
    clr();
    go(0);
    chk("t5_done", 32'(bus.done), 32'd1);
    chk("t5_abclr", 32'(bus.aborted), 32'd0);
    tick();
    chk("t5_idle", {bus.busy, bus.done}, 32'd0);
    chk("t5_nstart0", n_start, 0);
    for (int i = 0; i < 8; i++)
      wr(i, 4'd1, 4'd0, 16'h0, 8'd0);
    clr();
    go(15);
    wait_end(400, "t5_end");
    chk("t5_nstart8", n_start, 8);
    chk("t5_layer", 32'(bus.layer_idx), 32'd7);
    chk("t5_buf", 32'(bus.buf_sel), 32'd1);

    // T6: dropped write while busy, stale eng_done
    eng_dly = 10;
    wr(0, 4'd1, 4'd0, 16'h4000, 8'd8);
    wr(1, 4'd1, 4'd0, 16'h0, 8'd0);
    clr();
    go(2);
    tick();
    wr(0, 4'hF, 4'hF, 16'h5555, 8'd9);
    wait_end(300, "t6_end");
    go(1);
    tick();
    chk("t6_req", 32'(bus.wl_req), 32'd1);
    chk("t6_wbase", 32'(bus.wl_base), 32'h4000);
    chk("t6_wlen", 32'(bus.wl_len), 32'd8);
    eng_force = 1'b1;
    bus.eng_done = 1'b1;
    wait_start(0, 50, "t6_start");
    repeat (3) tick();
    chk("t6_no_early", 32'(bus.done), 32'd0);
    tick();
    chk("t6_done", 32'(bus.done), 32'd1);
    eng_force = 1'b0;
    bus.eng_done = 1'b0;
    tick();
    chk("t6_idle", 32'(bus.busy), 32'd0);

    // async reset mid-run
    go(2);
    repeat (3) tick();
    #1;
    rst_n = 1'b0;
    #1;
    chk("ar_outs",
        {bus.busy, bus.wl_req, bus.eng_start,
         bus.done, bus.buf_sel}, 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("ar_idle", 32'(bus.busy), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d",
             n_chk, n_fail);
    $finish;
  end

endmodule
